// File: rtl/pio_pkg.sv
// pio_pkg: shared definitions for the PIO host-side command responder.
//   - command action codes decoded from the host 'action' field
//   - instruction/address/data field widths
//   - bit offsets of the fields in the status word returned by the status read
//   - pack_status(): assembles the status word from per-machine flag vectors
package pio_pkg;

    localparam int INSTR_W    = 16;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 32;

    // Each status field is one bit per machine, four machines wide.
    localparam int ST_FIELD_W  = 4;
    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 4;
    localparam int ST_RX_EMPTY = 8;
    localparam int ST_RX_FULL  = 12;
    localparam int ST_RX_UNF   = 16;
    localparam int ST_TX_OVF   = 20;

    typedef enum logic [3:0] {
        ACT_NOP         = 4'd0,
        ACT_IMEM_WR     = 4'd1,
        ACT_SET_WRAP    = 4'd2,
        ACT_TX_PUSH     = 4'd3,
        ACT_RX_PULL     = 4'd4,
        ACT_SET_PINS    = 4'd5,
        ACT_ENABLE      = 4'd6,
        ACT_SET_DIV     = 4'd7,
        ACT_SET_SIDESET = 4'd8,
        ACT_STATUS      = 4'd9,
        ACT_RESTART     = 4'd10
    } pio_action_e;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic [ST_FIELD_W-1:0] tx_ovf,
        input logic [ST_FIELD_W-1:0] rx_unf,
        input logic [ST_FIELD_W-1:0] rx_full,
        input logic [ST_FIELD_W-1:0] rx_empty,
        input logic [ST_FIELD_W-1:0] tx_full,
        input logic [ST_FIELD_W-1:0] tx_empty
    );
        logic [DATA_W-1:0] w_word;
        w_word = '0;
        w_word[ST_TX_EMPTY +: ST_FIELD_W] = tx_empty;
        w_word[ST_TX_FULL  +: ST_FIELD_W] = tx_full;
        w_word[ST_RX_EMPTY +: ST_FIELD_W] = rx_empty;
        w_word[ST_RX_FULL  +: ST_FIELD_W] = rx_full;
        w_word[ST_RX_UNF   +: ST_FIELD_W] = rx_unf;
        w_word[ST_TX_OVF   +: ST_FIELD_W] = tx_ovf;
        return w_word;
    endfunction

endpackage

// File: rtl/pio_fifo.sv
// pio_fifo: circular-buffer FIFO used for the per-machine TX and RX queues.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata       - enqueue request; dropped while full
//   pop               - dequeue request; ignored while empty
//   rdata             - head entry, combinational, valid only when !empty
//   full, empty       - occupancy flags
//   count             - number of stored entries (log2(DEPTH)+1 bits)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module pio_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = '0;
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A pop on an empty FIFO is discarded even when a push arrives in the same cycle.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == CNT_ZERO);
    assign count = r_count;
    assign rdata = r_mem[r_rptr];

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pio_ctrl.sv
// pio_ctrl: host-side command responder for the PIO block.
// Decodes action/mindex/index/din each cycle and:
//   - writes the shared 32x16 instruction memory (read combinationally per machine)
//   - updates per-machine config registers (wrap, divider, pins, sideset, enable)
//   - pushes host words into per-machine TX FIFOs, pulls words from RX FIFOs
//   - returns pulled data or a status word on the registered dout
// Ports: clk, reset (sync, active-high); mindex/action/index/din command inputs;
//   dout read data; imem_raddr/imem_rdata instruction fetch; wrap_top/wrap_target,
//   div_int/div_frac, pins, sideset, en, restart config outputs; tx_pop/tx_data/
//   tx_empty machine-side TX port; rx_push/rx_data/rx_full machine-side RX port.
// Per-machine buses are packed, machine g at slice [g*W +: W]. NSM is at most 4.
module pio_ctrl
    import pio_pkg::*;
#(
    parameter int NSM        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mindex,
    input  logic [3:0]              action,
    input  logic [ADDR_W-1:0]       index,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    input  logic [ADDR_W*NSM-1:0]   imem_raddr,
    output logic [INSTR_W*NSM-1:0]  imem_rdata,
    output logic [ADDR_W*NSM-1:0]   wrap_top,
    output logic [ADDR_W*NSM-1:0]   wrap_target,
    output logic [16*NSM-1:0]       div_int,
    output logic [8*NSM-1:0]        div_frac,
    output logic [DATA_W*NSM-1:0]   pins,
    output logic [5*NSM-1:0]        sideset,
    output logic [NSM-1:0]          en,
    output logic [NSM-1:0]          restart,
    input  logic [NSM-1:0]          tx_pop,
    output logic [DATA_W*NSM-1:0]   tx_data,
    output logic [NSM-1:0]          tx_empty,
    input  logic [NSM-1:0]          rx_push,
    input  logic [DATA_W*NSM-1:0]   rx_data,
    output logic [NSM-1:0]          rx_full
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [INSTR_W-1:0]      r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0]       r_dout;
    logic [ADDR_W*NSM-1:0]   r_wrap_top;
    logic [ADDR_W*NSM-1:0]   r_wrap_target;
    logic [16*NSM-1:0]       r_div_int;
    logic [8*NSM-1:0]        r_div_frac;
    logic [DATA_W*NSM-1:0]   r_pins;
    logic [5*NSM-1:0]        r_sideset;
    logic [NSM-1:0]          r_en;
    logic [NSM-1:0]          r_restart;
    logic [NSM-1:0]          r_tx_ovf;
    logic [NSM-1:0]          r_rx_unf;

    logic                    w_sel_ok;
    logic [NSM-1:0]          w_sel;
    logic [NSM-1:0]          w_tx_push;
    logic [NSM-1:0]          w_rx_pop;
    logic [NSM-1:0]          w_tx_full;
    logic [NSM-1:0]          w_tx_empty;
    logic [NSM-1:0]          w_rx_full;
    logic [NSM-1:0]          w_rx_empty;
    logic [DATA_W-1:0]       w_tx_head  [NSM];
    logic [DATA_W-1:0]       w_rx_head  [NSM];
    logic [CNT_W-1:0]        w_tx_count [NSM];
    logic [CNT_W-1:0]        w_rx_count [NSM];

    // Commands addressed to a machine index that does not exist are ignored.
    assign w_sel_ok = (32'(mindex) < NSM);

    for (genvar g = 0; g < NSM; g++) begin : g_sm
        assign w_sel[g]     = w_sel_ok && (mindex == 2'(g));
        assign w_tx_push[g] = w_sel[g] && (action == ACT_TX_PUSH);
        // The RX dequeue is gated on the pre-edge count so an empty pull never pops.
        assign w_rx_pop[g]  = w_sel[g] && (action == ACT_RX_PULL) && (w_rx_count[g] != CNT_ZERO);

        pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_tx_push[g]),
            .wdata (din),
            .pop   (tx_pop[g]),
            .rdata (w_tx_head[g]),
            .full  (w_tx_full[g]),
            .empty (w_tx_empty[g]),
            .count (w_tx_count[g])
        );

        pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (rx_push[g]),
            .wdata (rx_data[g*DATA_W +: DATA_W]),
            .pop   (w_rx_pop[g]),
            .rdata (w_rx_head[g]),
            .full  (w_rx_full[g]),
            .empty (w_rx_empty[g]),
            .count (w_rx_count[g])
        );

        assign tx_data[g*DATA_W +: DATA_W]     = w_tx_head[g];
        assign imem_rdata[g*INSTR_W +: INSTR_W] = r_imem[imem_raddr[g*ADDR_W +: ADDR_W]];
    end

    // Shared instruction memory write port; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && (action == ACT_IMEM_WR)) begin
            r_imem[index] <= din[INSTR_W-1:0];
        end
    end

    // Command decode: config registers, sticky flags, restart pulses and dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout        <= '0;
            r_wrap_top    <= '0;
            r_wrap_target <= '0;
            r_div_int     <= '0;
            r_div_frac    <= '0;
            r_pins        <= '0;
            r_sideset     <= '0;
            r_en          <= '0;
            r_restart     <= '0;
            r_tx_ovf      <= '0;
            r_rx_unf      <= '0;
        end else begin
            r_restart <= '0;
            if (w_sel_ok) begin
                case (action)
                    ACT_SET_WRAP: begin
                        r_wrap_top[mindex*ADDR_W +: ADDR_W]    <= din[4:0];
                        r_wrap_target[mindex*ADDR_W +: ADDR_W] <= din[12:8];
                    end
                    ACT_TX_PUSH: begin
                        // The FIFO drops the word itself; here we only record the loss.
                        if (w_tx_count[mindex] == CNT_FULL) begin
                            r_tx_ovf[mindex] <= 1'b1;
                        end
                    end
                    ACT_RX_PULL: begin
                        if (w_rx_count[mindex] != CNT_ZERO) begin
                            r_dout <= w_rx_head[mindex];
                        end else begin
                            r_dout           <= 32'd0;
                            r_rx_unf[mindex] <= 1'b1;
                        end
                    end
                    ACT_SET_PINS:    r_pins[mindex*DATA_W +: DATA_W] <= din;
                    ACT_ENABLE:      r_en[mindex] <= din[0];
                    ACT_SET_DIV: begin
                        r_div_int[mindex*16 +: 16] <= din[23:8];
                        r_div_frac[mindex*8 +: 8]  <= din[7:0];
                    end
                    ACT_SET_SIDESET: r_sideset[mindex*5 +: 5] <= din[4:0];
                    ACT_STATUS: begin
                        // dout captures the flags before this read clears them.
                        r_dout   <= pack_status(4'(r_tx_ovf), 4'(r_rx_unf), 4'(w_rx_full),
                                                4'(w_rx_empty), 4'(w_tx_full), 4'(w_tx_empty));
                        r_tx_ovf <= '0;
                        r_rx_unf <= '0;
                    end
                    ACT_RESTART:     r_restart[mindex] <= 1'b1;
                    default:         r_dout <= r_dout;
                endcase
            end else begin
                r_dout <= r_dout;
            end
        end
    end

    assign dout        = r_dout;
    assign wrap_top    = r_wrap_top;
    assign wrap_target = r_wrap_target;
    assign div_int     = r_div_int;
    assign div_frac    = r_div_frac;
    assign pins        = r_pins;
    assign sideset     = r_sideset;
    assign en          = r_en;
    assign restart     = r_restart;
    assign tx_empty    = w_tx_empty;
    assign rx_full     = w_rx_full;

endmodule

// File: tb/tb_pio_ctrl.sv
// tb_pio_ctrl: directed test-plan steps followed by a randomized phase, all
// checked against a queue-based reference model of the command responder.
module tb_pio_ctrl;
    import pio_pkg::*;

    localparam int NSM = 4;
    localparam int D   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           mindex;
    logic [3:0]           action;
    logic [4:0]           index;
    logic [31:0]          din;
    logic [31:0]          dout;
    logic [5*NSM-1:0]     imem_raddr;
    logic [16*NSM-1:0]    imem_rdata;
    logic [5*NSM-1:0]     wrap_top;
    logic [5*NSM-1:0]     wrap_target;
    logic [16*NSM-1:0]    div_int;
    logic [8*NSM-1:0]     div_frac;
    logic [32*NSM-1:0]    pins;
    logic [5*NSM-1:0]     sideset;
    logic [NSM-1:0]       en;
    logic [NSM-1:0]       restart;
    logic [NSM-1:0]       tx_pop;
    logic [32*NSM-1:0]    tx_data;
    logic [NSM-1:0]       tx_empty;
    logic [NSM-1:0]       rx_push;
    logic [32*NSM-1:0]    rx_data;
    logic [NSM-1:0]       rx_full;

    always #5 clk = ~clk;

    pio_ctrl #(.NSM(NSM), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .mindex(mindex), .action(action), .index(index),
        .din(din), .dout(dout), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .wrap_top(wrap_top), .wrap_target(wrap_target), .div_int(div_int),
        .div_frac(div_frac), .pins(pins), .sideset(sideset), .en(en),
        .restart(restart), .tx_pop(tx_pop), .tx_data(tx_data), .tx_empty(tx_empty),
        .rx_push(rx_push), .rx_data(rx_data), .rx_full(rx_full)
    );

    // Reference model state
    logic [15:0] m_imem   [32];
    bit          m_imem_v [32];
    logic [31:0] m_tx [NSM][$];
    logic [31:0] m_rx [NSM][$];
    logic [31:0] m_dout;
    logic [4:0]  m_wtop [NSM];
    logic [4:0]  m_wtgt [NSM];
    logic [15:0] m_dint [NSM];
    logic [7:0]  m_dfrac[NSM];
    logic [31:0] m_pins [NSM];
    logic [4:0]  m_ss   [NSM];
    logic [NSM-1:0] m_en, m_restart, m_ovf, m_unf;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [NSM-1:0] txf, txe, rxf, rxe;
        int m;
        m = int'(mindex);
        if (reset) begin
            m_dout = 32'd0; m_en = '0; m_restart = '0; m_ovf = '0; m_unf = '0;
            for (int i = 0; i < NSM; i++) begin
                m_tx[i].delete(); m_rx[i].delete();
                m_wtop[i] = 5'd0; m_wtgt[i] = 5'd0; m_dint[i] = 16'd0;
                m_dfrac[i] = 8'd0; m_pins[i] = 32'd0; m_ss[i] = 5'd0;
            end
            return;
        end
        for (int i = 0; i < NSM; i++) begin
            txe[i] = (m_tx[i].size() == 0);
            txf[i] = (m_tx[i].size() == D);
            rxe[i] = (m_rx[i].size() == 0);
            rxf[i] = (m_rx[i].size() == D);
        end
        m_restart = '0;
        case (action)
            4'd1: begin m_imem[index] = din[15:0]; m_imem_v[index] = 1'b1; end
            4'd2: begin m_wtop[m] = din[4:0]; m_wtgt[m] = din[12:8]; end
            4'd3: if (txf[m]) m_ovf[m] = 1'b1; else m_tx[m].push_back(din);
            4'd4: if (!rxe[m]) m_dout = m_rx[m].pop_front();
                  else begin m_dout = 32'd0; m_unf[m] = 1'b1; end
            4'd5: m_pins[m] = din;
            4'd6: m_en[m] = din[0];
            4'd7: begin m_dint[m] = din[23:8]; m_dfrac[m] = din[7:0]; end
            4'd8: m_ss[m] = din[4:0];
            4'd9: begin
                m_dout = {8'd0, m_ovf, m_unf, rxf, rxe, txf, txe};
                m_ovf = '0; m_unf = '0;
            end
            4'd10: m_restart[m] = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < NSM; i++) begin
            if (tx_pop[i] && !txe[i]) void'(m_tx[i].pop_front());
            if (rx_push[i] && !rxf[i]) m_rx[i].push_back(rx_data[i*32 +: 32]);
        end
    endtask

    task automatic check_all();
        logic [NSM-1:0] exp_txe, exp_rxf;
        logic [4:0] a;
        for (int i = 0; i < NSM; i++) begin
            exp_txe[i] = (m_tx[i].size() == 0);
            exp_rxf[i] = (m_rx[i].size() == D);
        end
        chk("dout", dout, m_dout);
        chk("en", 32'(en), 32'(m_en));
        chk("restart", 32'(restart), 32'(m_restart));
        chk("tx_empty", 32'(tx_empty), 32'(exp_txe));
        chk("rx_full", 32'(rx_full), 32'(exp_rxf));
        for (int i = 0; i < NSM; i++) begin
            chk($sformatf("wrap_top[%0d]", i), 32'(wrap_top[i*5 +: 5]), 32'(m_wtop[i]));
            chk($sformatf("wrap_target[%0d]", i), 32'(wrap_target[i*5 +: 5]), 32'(m_wtgt[i]));
            chk($sformatf("div_int[%0d]", i), 32'(div_int[i*16 +: 16]), 32'(m_dint[i]));
            chk($sformatf("div_frac[%0d]", i), 32'(div_frac[i*8 +: 8]), 32'(m_dfrac[i]));
            chk($sformatf("pins[%0d]", i), pins[i*32 +: 32], m_pins[i]);
            chk($sformatf("sideset[%0d]", i), 32'(sideset[i*5 +: 5]), 32'(m_ss[i]));
            if (m_tx[i].size() != 0)
                chk($sformatf("tx_data[%0d]", i), tx_data[i*32 +: 32], m_tx[i][0]);
            a = imem_raddr[i*5 +: 5];
            if (m_imem_v[a])
                chk($sformatf("imem_rdata[%0d]", i), 32'(imem_rdata[i*16 +: 16]), 32'(m_imem[a]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_act(input logic [3:0] a, input logic [1:0] m, input logic [31:0] d);
        action = a; mindex = m; din = d;
        cycle();
        action = 4'd0; tx_pop = '0; rx_push = '0;
    endtask

    logic [15:0] last_word;
    logic [31:0] w;

    initial begin
        for (int i = 0; i < 32; i++) m_imem_v[i] = 1'b0;
        reset = 1'b1; mindex = 2'd0; action = 4'd0; index = 5'd0; din = 32'd0;
        imem_raddr = '0; tx_pop = '0; rx_push = '0; rx_data = '0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_dout", dout, 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_tx_empty", 32'(tx_empty), 32'hF);
        chk("rst_rx_full", 32'(rx_full), 32'd0);

        // Instruction memory: 12 writes, all machines fetch address 11
        for (int i = 0; i < 12; i++) begin
            index = 5'(i);
            w = $urandom;
            last_word = w[15:0];
            do_act(4'd1, 2'($urandom_range(0, 3)), w);
        end
        imem_raddr = {4{5'd11}};
        do_act(4'd0, 2'd0, 32'd0);
        for (int i = 0; i < NSM; i++)
            chk($sformatf("plan_imem_m%0d", i), 32'(imem_rdata[i*16 +: 16]), 32'(last_word));

        // Divider on machine 1 only
        do_act(4'd7, 2'd1, 32'h00FF_FF00);
        chk("plan_div_int1", 32'(div_int[31:16]), 32'h0000_FFFF);
        chk("plan_div_frac1", 32'(div_frac[15:8]), 32'd0);
        chk("plan_div_int0", 32'(div_int[15:0]), 32'd0);

        // TX overflow on machine 0
        for (int k = 0; k < 5; k++) do_act(4'd3, 2'd0, 32'h1000_0000 + 32'(k));
        chk("plan_tx_head", tx_data[31:0], 32'h1000_0000);
        do_act(4'd9, 2'd0, 32'd0);
        chk("plan_st_tx_full0", 32'(dout[4]), 32'd1);
        chk("plan_st_tx_ovf0", 32'(dout[20]), 32'd1);
        do_act(4'd9, 2'd0, 32'd0);
        chk("plan_st_tx_ovf0_clr", 32'(dout[20]), 32'd0);

        // RX underflow then a real pull on machine 1
        do_act(4'd4, 2'd1, 32'd0);
        chk("plan_rx_unf_dout", dout, 32'd0);
        do_act(4'd9, 2'd0, 32'd0);
        chk("plan_st_rx_unf1", 32'(dout[17]), 32'd1);
        rx_push = 4'b0010; rx_data = '0; rx_data[63:32] = 32'hDEAD_BEEF;
        do_act(4'd0, 2'd0, 32'd0);
        do_act(4'd4, 2'd1, 32'd0);
        chk("plan_rx_pull", dout, 32'hDEAD_BEEF);

        // Simultaneous push/pop at count 2 keeps the count and order
        tx_pop = 4'b0001; do_act(4'd0, 2'd0, 32'd0);
        tx_pop = 4'b0001; do_act(4'd0, 2'd0, 32'd0);
        tx_pop = 4'b0001; do_act(4'd3, 2'd0, 32'h2222_2222);
        chk("plan_pp_head", tx_data[31:0], 32'h1000_0003);
        do_act(4'd9, 2'd0, 32'd0);
        chk("plan_pp_not_full", 32'(dout[4]), 32'd0);
        chk("plan_pp_not_empty", 32'(dout[0]), 32'd0);
        tx_pop = 4'b0001; do_act(4'd0, 2'd0, 32'd0);
        chk("plan_pp_order", tx_data[31:0], 32'h2222_2222);

        // Reset with TX holding 3 entries and all machines enabled
        do_act(4'd3, 2'd0, 32'h3333_0001);
        do_act(4'd3, 2'd0, 32'h3333_0002);
        for (int i = 0; i < NSM; i++) do_act(4'd6, 2'(i), 32'd1);
        do_act(4'd9, 2'd0, 32'd0);
        chk("plan_pre_rst_en", 32'(en), 32'hF);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("plan_rst_tx_empty", 32'(tx_empty), 32'hF);
        chk("plan_rst_en", 32'(en), 32'd0);
        chk("plan_rst_dout", dout, 32'd0);

        // Randomized phase, push/pull weighted up
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0: action = 4'd3;
                1: action = 4'd4;
                default: action = 4'($urandom_range(0, 15));
            endcase
            mindex = 2'($urandom);
            index = 5'($urandom);
            din = $urandom;
            tx_pop = 4'($urandom);
            rx_push = 4'($urandom);
            for (int i = 0; i < NSM; i++) rx_data[i*32 +: 32] = $urandom;
            imem_raddr = 20'($urandom);
            cycle();
        end
        reset = 1'b0; action = 4'd0; tx_pop = '0; rx_push = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pio_ctrl.md
# pio_ctrl

Host-side command responder for the PIO block. It decodes the `action`/`index`/`mindex`/`din` command stream issued by the loader or CPU. Decoded commands write the shared 32×16 instruction memory and the per-machine configuration registers, and move data through per-machine TX/RX FIFOs. Read data and status return on `dout`. Up to four state machines consume its outputs.

## Interface
- `NSM`, 4: number of state machines; `mindex` selects one.
- `FIFO_DEPTH`, 4: entries per TX and per RX FIFO; power of two.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mindex` in 2: target machine for per-machine actions.
- `action` in 4: command; 0 = idle.
- `index` in 5: instruction address for action 1.
- `din` in 32: command payload.
- `dout` out 32: registered read data.
- `imem_raddr` in 5·NSM: per-machine instruction fetch address.
- `imem_rdata` out 16·NSM: combinational instruction read.
- `wrap_top`, `wrap_target` out 5·NSM each.
- `div_int` out 16·NSM, `div_frac` out 8·NSM.
- `pins` out 32·NSM: raw pin-group word.
- `sideset` out 5·NSM: [2:0] count, [3] optional, [4] pindirs.
- `en` out NSM: machine enables.
- `restart` out NSM: one-cycle restart pulses.
- `tx_pop` in NSM; `tx_data` out 32·NSM; `tx_empty` out NSM.
- `rx_push` in NSM; `rx_data` in 32·NSM; `rx_full` out NSM.

## Operation
Actions apply to machine `mindex` unless noted:
- 1, write instruction: `imem[index] <= din[15:0]`. The memory is shared across machines; `mindex` is ignored.
- 2, set wrap: `wrap_top <= din[4:0]`, `wrap_target <= din[12:8]`.
- 3, push TX: `din` is enqueued to TX[mindex]. If the FIFO is full, the write is dropped and sticky `tx_ovf[mindex]` is set.
- 4, pull RX: `dout <= ` RX[mindex] head, then dequeue. If the FIFO is empty, `dout <= 0` and sticky `rx_unf[mindex]` is set.
- 5, set pins: `pins <= din`.
- 6, enable: `en[mindex] <= din[0]`.
- 7, set divider: `div_int <= din[23:8]`, `div_frac <= din[7:0]`.
- 8, set sideset: `sideset <= din[4:0]`.
- 9, read status: `dout <= {tx_ovf[3:0], rx_unf[3:0], rx_full[3:0], rx_empty[3:0], tx_full[3:0], tx_empty[3:0]}`, zero-extended. The read then clears both sticky vectors; `dout` shows the pre-clear values.
- 10, restart: one-cycle pulse on `restart[mindex]`.
- 0 and 11–15: no effect; `dout` holds its value.

FIFO rules:
- Circular buffers with write pointer, read pointer and a count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- `tx_data` shows the head combinationally and is valid only when `!tx_empty`.
- `tx_pop` while empty is ignored.
- `rx_push` while full is dropped; no flag is set, because the machine stalls on `rx_full`.
- A simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- A simultaneous push and pop on an empty FIFO is a push only; the pop is ignored.

## Timing
- Every action takes effect at the clock edge where it is sampled. Config outputs change one cycle after the command.
- `dout` latency is one cycle: an action 4 or 9 in cycle N produces valid `dout` in cycle N+1.
- Back-to-back actions are accepted every cycle with no stall or handshake.
- An instruction written in cycle N is readable on `imem_rdata` from cycle N+1.
- Reset values:
  - `dout`, `en`, `restart`, sticky flags, all config outputs: 0.
  - FIFOs: empty (`tx_empty` = all ones, `rx_full` = 0).
  - Instruction memory is not reset.
- Reset mid-stream discards all FIFO contents and disables every machine in the same edge.

## Structure
- Package `pio_pkg`:
  - action codes `ACT_NOP` … `ACT_RESTART` (0–10);
  - field widths `INSTR_W`=16, `ADDR_W`=5, `DATA_W`=32;
  - status bit offsets.
- Sub-module `pio_fifo` (parameters DEPTH and WIDTH; ports push/pop/data/full/empty/count), instantiated 2·NSM times.

## Test plan
- Write 12 instructions (actions 1, index 0..11), then drive `imem_raddr` of machine 2 to 11 -> `imem_rdata` equals the last word written; the other machines see the same memory.
- Action 7 with din=0x00FFFF00 on mindex 1 -> `div_int[1]`=0xFFFF and `div_frac[1]`=0 one cycle later; machine 0 is unchanged.
- Five action-3 pushes to machine 0 with FIFO_DEPTH=4 -> `tx_full` is set and the fifth word is dropped. A status read shows `tx_ovf[0]`=1; a second status read shows 0.
- Pull on an empty RX -> `dout`=0 and `rx_unf` is set. Then `rx_push` of 0xDEADBEEF followed by action 4 -> `dout`=0xDEADBEEF in the next cycle.
- `tx_pop` and action 3 in the same cycle at count 2 -> count stays 2 and FIFO order is preserved.
- Assert reset with TX holding 3 entries and `en`=0xF -> next cycle `tx_empty`=0xF, `en`=0, `dout`=0.
